// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage CPU: opcodes, forward-select
// encodings, the ID/EX halt FSM state type and a register-match helper.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LB  = 4'hA;
  localparam logic [3:0] OP_BR  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] FWD_NONE = 3'b000;
  localparam logic [2:0] FWD_WB   = 3'b001;
  localparam logic [2:0] FWD_MEM  = 3'b010;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // A source depends on a writer only if it is actually read and the writer
  // targets a real register; r0 is hardwired and never a dependency.
  function automatic logic src_match(input logic             used,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return used && (dst != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode-side inputs, downstream writer info and the
// registered EX-side outputs. master = ID/pipeline side, slave = id_ex_stage.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0] instr_ID, RegData1_ID, RegData2_ID, pcs_ID;
  logic [REG_W-1:0]  rs_ID, rt_ID, rd_ID;
  logic              rs_used_ID, rt_used_ID;
  logic              valid_ID, RegWrite_ID, MemRead_ID, MemWrite_ID;
  logic              MemToReg_ID, LdByte_ID, MemOp_ID, Halt_ID;
  logic [REG_W-1:0]  rd_MEM, rd_WB;
  logic              RegWrite_MEM, RegWrite_WB;
  logic              flush, stall_ext;

  logic [DATA_W-1:0] instr_EX, RegData1_EX, RegData2_EX, pcs_EX;
  logic [REG_W-1:0]  rd_EX;
  logic              valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX;
  logic              MemToReg_EX, LdByte_EX, MemOp_EX;
  logic [2:0]        ForwardA, ForwardB;
  logic              stall_ID, halted;

  modport master (
    output instr_ID, RegData1_ID, RegData2_ID, pcs_ID, rs_ID, rt_ID, rd_ID,
           rs_used_ID, rt_used_ID, valid_ID, RegWrite_ID, MemRead_ID,
           MemWrite_ID, MemToReg_ID, LdByte_ID, MemOp_ID, Halt_ID,
           rd_MEM, rd_WB, RegWrite_MEM, RegWrite_WB, flush, stall_ext,
    input  instr_EX, RegData1_EX, RegData2_EX, pcs_EX, rd_EX, valid_EX,
           RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, LdByte_EX,
           MemOp_EX, ForwardA, ForwardB, stall_ID, halted
  );

  modport slave (
    input  instr_ID, RegData1_ID, RegData2_ID, pcs_ID, rs_ID, rt_ID, rd_ID,
           rs_used_ID, rt_used_ID, valid_ID, RegWrite_ID, MemRead_ID,
           MemWrite_ID, MemToReg_ID, LdByte_ID, MemOp_ID, Halt_ID,
           rd_MEM, rd_WB, RegWrite_MEM, RegWrite_WB, flush, stall_ext,
    output instr_EX, RegData1_EX, RegData2_EX, pcs_EX, rd_EX, valid_EX,
           RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, LdByte_EX,
           MemOp_EX, ForwardA, ForwardB, stall_ID, halted
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard detection and ForwardA/ForwardB select generation.
// Build option ID_EX_FWD_EN: defined = forwarding with load-use-only stalls;
// undefined = no forwarding, stall on any EX or MEM writer dependency.
module hazard_fwd_unit
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             rs_used_ID,
  input  logic             rt_used_ID,
  input  logic             valid_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] rd_EX,
  input  logic [REG_W-1:0] rs_EX,
  input  logic [REG_W-1:0] rt_EX,
  input  logic [REG_W-1:0] rd_MEM,
  input  logic             RegWrite_MEM,
  input  logic [REG_W-1:0] rd_WB,
  input  logic             RegWrite_WB,
  output logic             hazard,
  output logic [2:0]       fwd_a,
  output logic [2:0]       fwd_b
);

`ifdef ID_EX_FWD_EN
  logic ex_is_load;

  // Only a load in EX cannot be covered by forwarding: its data arrives too late.
  assign ex_is_load = valid_EX & MemRead_EX & RegWrite_EX;
  assign hazard     = ex_is_load & (src_match(rs_used_ID, rs_ID, rd_EX) |
                                    src_match(rt_used_ID, rt_ID, rd_EX));

  // Pick the youngest producer per operand: MEM beats WB, all gated by a live EX slot.
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (valid_EX) begin
      if (RegWrite_MEM && src_match(1'b1, rs_EX, rd_MEM))     fwd_a = FWD_MEM;
      else if (RegWrite_WB && src_match(1'b1, rs_EX, rd_WB))  fwd_a = FWD_WB;
      if (RegWrite_MEM && src_match(1'b1, rt_EX, rd_MEM))     fwd_b = FWD_MEM;
      else if (RegWrite_WB && src_match(1'b1, rt_EX, rd_WB))  fwd_b = FWD_WB;
    end
  end
`else
  logic ex_hit, mem_hit;
  logic unused_fwd_inputs;

  // Without bypass paths any in-flight writer ahead of WB must drain first;
  // the register file write-through covers the WB case.
  assign ex_hit  = valid_EX & RegWrite_EX &
                   (src_match(rs_used_ID, rs_ID, rd_EX) | src_match(rt_used_ID, rt_ID, rd_EX));
  assign mem_hit = RegWrite_MEM &
                   (src_match(rs_used_ID, rs_ID, rd_MEM) | src_match(rt_used_ID, rt_ID, rd_MEM));
  assign hazard  = ex_hit | mem_hit;
  assign fwd_a   = FWD_NONE;
  assign fwd_b   = FWD_NONE;

  assign unused_fwd_inputs = ^{rs_EX, rt_EX, rd_WB, RegWrite_WB, MemRead_EX};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall/bubble insertion, forward select
// outputs and the sticky RUN/HALT state. Build option ID_EX_FWD_EN selects
// forwarding (see hazard_fwd_unit).
//
// state | meaning
// RUN   | normal operation, loads ID into EX unless flushed or stalled
// HALT  | HLT reached EX; ID held, bubbles only, left only by rst
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  state_t           state_q, state_d;
  logic             hazard, in_halt, bubble, halt_load;
  logic [REG_W-1:0] rs_EX, rt_EX;

  hazard_fwd_unit u_hazard_fwd (
    .rs_ID        (bus.rs_ID),
    .rt_ID        (bus.rt_ID),
    .rs_used_ID   (bus.rs_used_ID),
    .rt_used_ID   (bus.rt_used_ID),
    .valid_EX     (bus.valid_EX),
    .RegWrite_EX  (bus.RegWrite_EX),
    .MemRead_EX   (bus.MemRead_EX),
    .rd_EX        (bus.rd_EX),
    .rs_EX        (rs_EX),
    .rt_EX        (rt_EX),
    .rd_MEM       (bus.rd_MEM),
    .RegWrite_MEM (bus.RegWrite_MEM),
    .rd_WB        (bus.rd_WB),
    .RegWrite_WB  (bus.RegWrite_WB),
    .hazard       (hazard),
    .fwd_a        (bus.ForwardA),
    .fwd_b        (bus.ForwardB)
  );

  // A flushed ID instruction is squashed, so flush also turns the load into a bubble.
  assign bubble    = bus.flush | hazard | in_halt;
  assign halt_load = ~bus.stall_ext & ~bubble & bus.valid_ID & bus.Halt_ID;

  // A taken branch overrides the hazard stall so the fetch redirect can proceed.
  assign bus.stall_ID = ~rst & ~bus.flush & (hazard | in_halt);
  assign bus.halted   = in_halt;

  // Halt state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: enter HALT when a live HLT actually lands in EX; HALT is sticky
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_load) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_halt = 1'b0;
    case (state_q)
      HALT:    in_halt = 1'b1;
      default: in_halt = 1'b0;
    endcase
  end

  // Control fields: cleared on a bubble so nothing downstream acts on it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_EX    <= 1'b0;
      bus.RegWrite_EX <= 1'b0;
      bus.MemRead_EX  <= 1'b0;
      bus.MemWrite_EX <= 1'b0;
      bus.MemToReg_EX <= 1'b0;
      bus.LdByte_EX   <= 1'b0;
      bus.MemOp_EX    <= 1'b0;
    end else if (!bus.stall_ext) begin
      if (bubble) begin
        bus.valid_EX    <= 1'b0;
        bus.RegWrite_EX <= 1'b0;
        bus.MemRead_EX  <= 1'b0;
        bus.MemWrite_EX <= 1'b0;
        bus.MemToReg_EX <= 1'b0;
        bus.LdByte_EX   <= 1'b0;
        bus.MemOp_EX    <= 1'b0;
      end else begin
        bus.valid_EX    <= bus.valid_ID;
        bus.RegWrite_EX <= bus.RegWrite_ID;
        bus.MemRead_EX  <= bus.MemRead_ID;
        bus.MemWrite_EX <= bus.MemWrite_ID;
        bus.MemToReg_EX <= bus.MemToReg_ID;
        bus.LdByte_EX   <= bus.LdByte_ID;
        bus.MemOp_EX    <= bus.MemOp_ID;
      end
    end
  end

  // Data fields and register indices: load on a real issue, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.instr_EX    <= '0;
      bus.RegData1_EX <= '0;
      bus.RegData2_EX <= '0;
      bus.pcs_EX      <= '0;
      bus.rd_EX       <= '0;
      rs_EX           <= '0;
      rt_EX           <= '0;
    end else if (!bus.stall_ext && !bubble) begin
      bus.instr_EX    <= bus.instr_ID;
      bus.RegData1_EX <= bus.RegData1_ID;
      bus.RegData2_EX <= bus.RegData2_ID;
      bus.pcs_EX      <= bus.pcs_ID;
      bus.rd_EX       <= bus.rd_ID;
      rs_EX           <= bus.rs_ID;
      rt_EX           <= bus.rt_ID;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a cycle-by-cycle vector table (expectations
// chosen per ID_EX_FWD_EN build) plus hand sequences for reset, full
// datapath transfer and asynchronous reset out of HALT.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  rs, rt, rd;
    logic        rsu, rtu, vld, rw, mr, hlt;
    logic [3:0]  rd_mem;
    logic        rw_mem;
    logic [3:0]  rd_wb;
    logic        rw_wb;
    logic        fl, sx;
    logic        e_st;
    logic [2:0]  e_fa, e_fb;
    logic        e_v, e_rw, e_mr;
    logic [3:0]  e_rd;
    logic [15:0] e_instr;
    logic        e_h;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [15:0] instr, input logic [3:0] rs, input logic [3:0] rt,
                     input logic [3:0] rd, input logic rsu, input logic rtu, input logic vld,
                     input logic rw, input logic mr, input logic hlt,
                     input logic [3:0] rd_mem, input logic rw_mem, input logic [3:0] rd_wb,
                     input logic rw_wb, input logic fl, input logic sx,
                     input logic e_st, input logic [2:0] e_fa, input logic [2:0] e_fb,
                     input logic e_v, input logic e_rw, input logic e_mr, input logic [3:0] e_rd,
                     input logic [15:0] e_instr, input logic e_h);
    vec_t v;
    v.instr = instr; v.rs = rs; v.rt = rt; v.rd = rd; v.rsu = rsu; v.rtu = rtu;
    v.vld = vld; v.rw = rw; v.mr = mr; v.hlt = hlt;
    v.rd_mem = rd_mem; v.rw_mem = rw_mem; v.rd_wb = rd_wb; v.rw_wb = rw_wb;
    v.fl = fl; v.sx = sx;
    v.e_st = e_st; v.e_fa = e_fa; v.e_fb = e_fb; v.e_v = e_v; v.e_rw = e_rw;
    v.e_mr = e_mr; v.e_rd = e_rd; v.e_instr = e_instr; v.e_h = e_h;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    bus.instr_ID = '0; bus.RegData1_ID = '0; bus.RegData2_ID = '0; bus.pcs_ID = '0;
    bus.rs_ID = '0; bus.rt_ID = '0; bus.rd_ID = '0;
    bus.rs_used_ID = 1'b0; bus.rt_used_ID = 1'b0; bus.valid_ID = 1'b0;
    bus.RegWrite_ID = 1'b0; bus.MemRead_ID = 1'b0; bus.MemWrite_ID = 1'b0;
    bus.MemToReg_ID = 1'b0; bus.LdByte_ID = 1'b0; bus.MemOp_ID = 1'b0; bus.Halt_ID = 1'b0;
    bus.rd_MEM = '0; bus.rd_WB = '0; bus.RegWrite_MEM = 1'b0; bus.RegWrite_WB = 1'b0;
    bus.flush = 1'b0; bus.stall_ext = 1'b0;
  endtask

  task automatic drive_row(input vec_t v);
    bus.instr_ID    = v.instr;
    bus.RegData1_ID = v.instr ^ 16'hA5A5;
    bus.RegData2_ID = ~v.instr;
    bus.pcs_ID      = v.instr + 16'd2;
    bus.rs_ID = v.rs; bus.rt_ID = v.rt; bus.rd_ID = v.rd;
    bus.rs_used_ID = v.rsu; bus.rt_used_ID = v.rtu; bus.valid_ID = v.vld;
    bus.RegWrite_ID = v.rw; bus.MemRead_ID = v.mr; bus.MemWrite_ID = 1'b0;
    bus.MemToReg_ID = v.mr; bus.LdByte_ID = 1'b0; bus.MemOp_ID = v.mr; bus.Halt_ID = v.hlt;
    bus.rd_MEM = v.rd_mem; bus.RegWrite_MEM = v.rw_mem;
    bus.rd_WB = v.rd_wb; bus.RegWrite_WB = v.rw_wb;
    bus.flush = v.fl; bus.stall_ext = v.sx;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_err = 0;

    // ---------------- reset with random inputs ----------------
    rst = 1'b1;
    bus.instr_ID = 16'($urandom); bus.RegData1_ID = 16'($urandom);
    bus.RegData2_ID = 16'($urandom); bus.pcs_ID = 16'($urandom);
    bus.rs_ID = 4'($urandom); bus.rt_ID = 4'($urandom); bus.rd_ID = 4'($urandom);
    bus.rs_used_ID = 1'b1; bus.rt_used_ID = 1'b1; bus.valid_ID = 1'($urandom);
    bus.RegWrite_ID = 1'($urandom); bus.MemRead_ID = 1'($urandom);
    bus.MemWrite_ID = 1'($urandom); bus.MemToReg_ID = 1'($urandom);
    bus.LdByte_ID = 1'($urandom); bus.MemOp_ID = 1'($urandom); bus.Halt_ID = 1'($urandom);
    bus.rd_MEM = bus.rs_ID; bus.RegWrite_MEM = 1'b1;
    bus.rd_WB = bus.rt_ID; bus.RegWrite_WB = 1'b1;
    bus.flush = 1'b0; bus.stall_ext = 1'($urandom);
    #12;
    check("rst valid_EX", 16'(bus.valid_EX), 16'd0);
    check("rst ctrl_EX", 16'({bus.RegWrite_EX, bus.MemRead_EX, bus.MemWrite_EX,
                               bus.MemToReg_EX, bus.LdByte_EX, bus.MemOp_EX}), 16'd0);
    check("rst instr_EX", bus.instr_EX, 16'd0);
    check("rst RegData1_EX", bus.RegData1_EX, 16'd0);
    check("rst RegData2_EX", bus.RegData2_EX, 16'd0);
    check("rst pcs_EX", bus.pcs_EX, 16'd0);
    check("rst rd_EX", 16'(bus.rd_EX), 16'd0);
    check("rst ForwardA", 16'(bus.ForwardA), 16'd0);
    check("rst ForwardB", 16'(bus.ForwardB), 16'd0);
    check("rst stall_ID", 16'(bus.stall_ID), 16'd0);
    check("rst halted", 16'(bus.halted), 16'd0);
    zero_inputs();
    @(negedge clk);
    rst = 1'b0;

    // ---------------- vector table ----------------
    //    instr    rs rt rd su tu v rw mr h  rdM wM rdW wW fl sx  st fa fb  v rw mr rd  instr    h
`ifdef ID_EX_FWD_EN
    add(16'h0123, 2, 3, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 16'h0123, 0);
    add(16'h1415, 1, 5, 4, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 16'h1415, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(16'h8460, 6, 0, 4, 1, 0, 1, 1, 1, 0, 4, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 4, 16'h8460, 0);
    add(16'h0544, 4, 4, 5, 1, 1, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4, 16'h8460, 0);
    add(16'h0544, 4, 4, 5, 1, 1, 1, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 16'h0544, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 0);
    add(16'h0623, 2, 3, 6, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6, 16'h0623, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 2, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(16'h0700, 0, 0, 7, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7, 16'h0700, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(16'h8060, 6, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 16'h8060, 0);
    add(16'h0500, 0, 0, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 16'h0500, 0);
    add(16'h8360, 6, 0, 3, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 16'h8360, 0);
    add(16'h2930, 9, 3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h2930, 0);
    add(16'h8260, 6, 0, 2, 1, 0, 1, 1, 1, 0, 9, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 16'h8260, 0);
    add(16'h0122, 2, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 16'h8260, 0);
    add(16'h0544, 4, 4, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 16'h0544, 0);
`else
    add(16'h0123, 2, 3, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 16'h0123, 0);
    add(16'h1415, 1, 5, 4, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0123, 0);
    add(16'h1415, 1, 5, 4, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0123, 0);
    add(16'h1415, 1, 5, 4, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 4, 16'h1415, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(16'h8460, 6, 0, 4, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 16'h8460, 0);
    add(16'h0544, 4, 4, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4, 16'h8460, 0);
    add(16'h0544, 4, 4, 5, 1, 1, 1, 1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4, 16'h8460, 0);
    add(16'h0544, 4, 4, 5, 1, 1, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 1, 0, 5, 16'h0544, 0);
    add(16'h0700, 0, 0, 7, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7, 16'h0700, 0);
    add(16'h0023, 2, 3, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0023, 0);
    add(16'h0700, 0, 0, 7, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7, 16'h0700, 0);
    add(16'h2930, 9, 7, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h2930, 0);
    add(16'h8260, 6, 0, 2, 1, 0, 1, 1, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 16'h8260, 0);
    add(16'h0122, 2, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 16'h8260, 0);
    add(16'h0544, 4, 4, 5, 1, 1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 16'h0544, 0);
`endif
    // stall_ext holds EX and the FSM even with flush and HLT present
    add(16'hF000, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 5, 16'h0544, 0);
    // flushed HLT becomes a bubble and does not halt
    add(16'hF000, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 16'h0544, 0);
    add(16'hF000, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'hF000, 1);
    add(16'h0123, 2, 3, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'hF000, 1);
    add(16'h0123, 2, 3, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'hF000, 1);
    add(16'h0123, 2, 3, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'hF000, 1);

    foreach (tv[i]) begin
      @(negedge clk);
      drive_row(tv[i]);
      #1;
      check($sformatf("row%0d stall_ID", i), 16'(bus.stall_ID), 16'(tv[i].e_st));
      check($sformatf("row%0d ForwardA", i), 16'(bus.ForwardA), 16'(tv[i].e_fa));
      check($sformatf("row%0d ForwardB", i), 16'(bus.ForwardB), 16'(tv[i].e_fb));
      @(posedge clk);
      #1;
      check($sformatf("row%0d valid_EX", i), 16'(bus.valid_EX), 16'(tv[i].e_v));
      check($sformatf("row%0d RegWrite_EX", i), 16'(bus.RegWrite_EX), 16'(tv[i].e_rw));
      check($sformatf("row%0d MemRead_EX", i), 16'(bus.MemRead_EX), 16'(tv[i].e_mr));
      check($sformatf("row%0d MemToReg_EX", i), 16'(bus.MemToReg_EX), 16'(tv[i].e_mr));
      check($sformatf("row%0d MemOp_EX", i), 16'(bus.MemOp_EX), 16'(tv[i].e_mr));
      check($sformatf("row%0d rd_EX", i), 16'(bus.rd_EX), 16'(tv[i].e_rd));
      check($sformatf("row%0d instr_EX", i), bus.instr_EX, tv[i].e_instr);
      check($sformatf("row%0d RegData1_EX", i), bus.RegData1_EX, tv[i].e_instr ^ 16'hA5A5);
      check($sformatf("row%0d RegData2_EX", i), bus.RegData2_EX, ~tv[i].e_instr);
      check($sformatf("row%0d pcs_EX", i), bus.pcs_EX, tv[i].e_instr + 16'd2);
      check($sformatf("row%0d halted", i), 16'(bus.halted), 16'(tv[i].e_h));
    end

    // ---------------- asynchronous reset out of HALT ----------------
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("halt stall_ID held", 16'(bus.stall_ID), 16'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async rst halted", 16'(bus.halted), 16'd0);
    check("async rst stall_ID", 16'(bus.stall_ID), 16'd0);
    check("async rst instr_EX", bus.instr_EX, 16'd0);
    check("async rst pcs_EX", bus.pcs_EX, 16'd0);
    zero_inputs();
    @(negedge clk);
    rst = 1'b0;

    // ---------------- full datapath transfer ----------------
    @(negedge clk);
    bus.instr_ID = 16'h9ABC; bus.RegData1_ID = 16'h1357; bus.RegData2_ID = 16'h2468;
    bus.pcs_ID = 16'h0042; bus.rd_ID = 4'hC; bus.rs_ID = 4'hA; bus.rt_ID = 4'hB;
    bus.valid_ID = 1'b1; bus.MemWrite_ID = 1'b1; bus.LdByte_ID = 1'b1; bus.MemOp_ID = 1'b1;
    #1;
    check("dp stall_ID after rst", 16'(bus.stall_ID), 16'd0);
    @(posedge clk);
    #1;
    check("dp1 instr_EX", bus.instr_EX, 16'h9ABC);
    check("dp1 RegData1_EX", bus.RegData1_EX, 16'h1357);
    check("dp1 RegData2_EX", bus.RegData2_EX, 16'h2468);
    check("dp1 pcs_EX", bus.pcs_EX, 16'h0042);
    check("dp1 rd_EX", 16'(bus.rd_EX), 16'hC);
    check("dp1 ctrl v/rw/mr/mw/m2r/lb/mop", 16'({bus.valid_EX, bus.RegWrite_EX, bus.MemRead_EX,
          bus.MemWrite_EX, bus.MemToReg_EX, bus.LdByte_EX, bus.MemOp_EX}), 16'b1001011);
    @(negedge clk);
    bus.instr_ID = 16'h8D10; bus.RegData1_ID = 16'hBEEF; bus.RegData2_ID = 16'hCAFE;
    bus.pcs_ID = 16'h0044; bus.rd_ID = 4'hD;
    bus.MemWrite_ID = 1'b0; bus.LdByte_ID = 1'b0; bus.MemOp_ID = 1'b0;
    bus.RegWrite_ID = 1'b1; bus.MemRead_ID = 1'b1; bus.MemToReg_ID = 1'b1;
    @(posedge clk);
    #1;
    check("dp2 RegData2_EX", bus.RegData2_EX, 16'hCAFE);
    check("dp2 pcs_EX", bus.pcs_EX, 16'h0044);
    check("dp2 ctrl v/rw/mr/mw/m2r/lb/mop", 16'({bus.valid_EX, bus.RegWrite_EX, bus.MemRead_EX,
          bus.MemWrite_EX, bus.MemToReg_EX, bus.LdByte_EX, bus.MemOp_EX}), 16'b1110100);
    @(negedge clk);
    bus.instr_ID = 16'h0111; bus.RegData1_ID = 16'h0001; bus.RegData2_ID = 16'h0002;
    bus.pcs_ID = 16'h0046; bus.rd_ID = 4'h1; bus.MemWrite_ID = 1'b1; bus.LdByte_ID = 1'b1;
    bus.MemOp_ID = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    #1;
    check("dp3 bubble ctrl", 16'({bus.valid_EX, bus.RegWrite_EX, bus.MemRead_EX,
          bus.MemWrite_EX, bus.MemToReg_EX, bus.LdByte_EX, bus.MemOp_EX}), 16'd0);
    check("dp3 RegData1_EX held", bus.RegData1_EX, 16'hBEEF);
    check("dp3 instr_EX held", bus.instr_EX, 16'h8D10);
    check("dp3 rd_EX held", 16'(bus.rd_EX), 16'hD);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
